// File: rtl/date_pkg.sv
// Shared definitions for the calendar controller: field select codes,
// FSM state encoding, BCD constants and BCD arithmetic helpers.
package date_pkg;

    localparam logic [3:0] SEL_DAY   = 4'd4;
    localparam logic [3:0] SEL_MONTH = 4'd5;
    localparam logic [3:0] SEL_YEAR  = 4'd6;

    localparam logic [4:0]  MONTH_DEC = 5'h12;
    localparam logic [15:0] YEAR_MAX  = 16'h9999;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UPDATE,
        ST_CLAMP
    } state_t;

    // Two-digit BCD day increment; callers never pass 39.
    function automatic logic [5:0] day_inc(input logic [5:0] d);
        return (d[3:0] == 4'd9) ? {d[5:4] + 2'd1, 4'd0} : {d[5:4], d[3:0] + 4'd1};
    endfunction

    // Two-digit BCD month increment; callers never pass 19.
    function automatic logic [4:0] month_inc(input logic [4:0] m);
        return (m[3:0] == 4'd9) ? 5'h10 : {m[4], m[3:0] + 4'd1};
    endfunction

    // Four-digit BCD year increment with ripple carry, 9999 wraps to 0000.
    function automatic logic [15:0] year_inc(input logic [15:0] y);
        logic [15:0] r;
        logic        c;
        r = y;
        c = 1'b1;
        if (y == YEAR_MAX) return 16'h0000;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Divisibility by 4 of a two-digit BCD value, evaluated on the digits.
    function automatic logic bcd_div4(input logic [7:0] v);
        if (v[4]) return (v[3:0] == 4'd2) || (v[3:0] == 4'd6);
        else      return (v[3:0] == 4'd0) || (v[3:0] == 4'd4) || (v[3:0] == 4'd8);
    endfunction

    // Gregorian leap rule: centuries fall back to testing the high digits.
    function automatic logic is_leap(input logic [7:0] yl, input logic [7:0] yh);
        return (yl != 8'h00) ? bcd_div4(yl) : bcd_div4(yh);
    endfunction

endpackage

// File: rtl/date_ctrl_if.sv
// Calendar controller signal bundle: control inputs from the clock top
// level and the BCD date outputs it displays.
interface date_ctrl_if;
    logic       day_carry;
    logic       adjust;
    logic [3:0] select;
    logic       add_n;
    logic [5:0] day;
    logic [4:0] month;
    logic [7:0] year_l;
    logic [7:0] year_h;
    logic       leap;
    logic       busy;

    modport master (
        output day_carry, adjust, select, add_n,
        input  day, month, year_l, year_h, leap, busy
    );

    modport slave (
        input  day_carry, adjust, select, add_n,
        output day, month, year_l, year_h, leap, busy
    );
endinterface

// File: rtl/date_dim_lut.sv
// Days-in-month lookup: BCD month plus leap flag to BCD day count.
module date_dim_lut
    import date_pkg::*;
(
    input  logic [4:0] month,
    input  logic       leap,
    output logic [5:0] dim
);

    // Month length table; unknown month codes fall back to 31.
    always_comb begin
        // NOTE: dim gets a value before the case so no path can leave it unassigned and infer a latch.
        dim = 6'h31;
        case (month)
            5'h02:                      dim = leap ? 6'h29 : 6'h28;
            5'h04, 5'h06, 5'h09, 5'h11: dim = 6'h30;
            default:                    dim = 6'h31;
        endcase
    end

endmodule

// File: rtl/date_ctrl.sv
// Calendar controller: advances the BCD date on day rollover in run mode
// and increments the selected field on debounced key presses in adjust mode.
module date_ctrl
    import date_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = 500000,
    parameter logic [5:0]  RST_DAY      = 6'h01,
    parameter logic [4:0]  RST_MONTH    = 5'h01,
    parameter logic [15:0] RST_YEAR     = 16'h2000
) (
    input  logic        clk,
    input  logic        clr,
    date_ctrl_if.slave  bus
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_PREV = CNT_W'(DEBOUNCE_CYC - 2);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;
    logic             press;

    state_t      state;
    logic        carry_pend;
    logic        op_adj;
    logic [3:0]  op_sel;
    logic [5:0]  day_q;
    logic [4:0]  month_q;
    logic [15:0] year_q;

    logic        leap;
    logic [5:0]  dim;
    logic        sel_valid;
    logic        carry_set;

    assign leap      = is_leap(year_q[7:0], year_q[15:8]);
    assign sel_valid = (bus.select == SEL_DAY) || (bus.select == SEL_MONTH) ||
                       (bus.select == SEL_YEAR);
    assign carry_set = bus.day_carry && !bus.adjust;

    date_dim_lut u_dim (
        .month (month_q),
        .leap  (leap),
        .dim   (dim)
    );

    // Key path: two-flop synchronizer, then a saturating stable-low counter
    // that emits one press pulse as it reaches its last count.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!clr) begin
            sync  <= 2'b11;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], bus.add_n};
            press <= 1'b0;
            if (sync[1]) begin
                cnt <= '0;
            end else if (cnt != CNT_LAST) begin
                cnt   <= cnt + 1'b1;
                press <= (cnt == CNT_PREV);
            end
        end
    end

    // Date sequencer: IDLE picks up a press or pending carry, UPDATE applies
    // the advance or field increment, CLAMP trims the day to the month length.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state      <= ST_IDLE;
            carry_pend <= 1'b0;
            op_adj     <= 1'b0;
            op_sel     <= 4'd0;
            day_q      <= RST_DAY;
            month_q    <= RST_MONTH;
            year_q     <= RST_YEAR;
        end else begin
            if (carry_set) carry_pend <= 1'b1;
            unique case (state)
                ST_IDLE: begin
                    if (press && bus.adjust && sel_valid) begin
                        state  <= ST_UPDATE;
                        op_adj <= 1'b1;
                        op_sel <= bus.select;
                    end else if (carry_pend) begin
                        state  <= ST_UPDATE;
                        op_adj <= 1'b0;
                    end
                end
                ST_UPDATE: begin
                    if (op_adj) begin
                        state <= ST_CLAMP;
                        case (op_sel)
                            SEL_DAY:   day_q   <= (day_q >= dim) ? 6'h01 : day_inc(day_q);
                            SEL_MONTH: month_q <= (month_q >= MONTH_DEC) ? 5'h01 : month_inc(month_q);
                            SEL_YEAR:  year_q  <= year_inc(year_q);
                            default:   ;
                        endcase
                    end else begin
                        state <= ST_IDLE;
                        // A carry arriving in this very cycle stays pending.
                        carry_pend <= carry_set;
                        if (day_q < dim) begin
                            day_q <= day_inc(day_q);
                        end else begin
                            day_q <= 6'h01;
                            if (month_q < MONTH_DEC) begin
                                month_q <= month_inc(month_q);
                            end else begin
                                month_q <= 5'h01;
                                year_q  <= year_inc(year_q);
                            end
                        end
                    end
                end
                ST_CLAMP: begin
                    state <= ST_IDLE;
                    if (day_q > dim) day_q <= dim;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.day    = day_q;
    assign bus.month  = month_q;
    assign bus.year_l = year_q[7:0];
    assign bus.year_h = year_q[15:8];
    assign bus.leap   = leap;
    assign bus.busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_date_ctrl.sv
// Directed bench for date_ctrl: run-mode rollovers, leap rules, adjust-mode
// increments with clamping, debounce glitch rejection and reset mid-update.
module tb_date_ctrl;
    import date_pkg::*;

    localparam int unsigned DB = 16;

    logic clk = 1'b0;
    logic clr;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    date_ctrl_if bus ();
    date_ctrl_if bus_eoy ();

    // Second instance reset to the last day of 9999 shares all stimulus.
    assign bus_eoy.day_carry = bus.day_carry;
    assign bus_eoy.adjust    = bus.adjust;
    assign bus_eoy.select    = bus.select;
    assign bus_eoy.add_n     = bus.add_n;

    date_ctrl #(.DEBOUNCE_CYC(DB)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    date_ctrl #(
        .DEBOUNCE_CYC (DB),
        .RST_DAY      (6'h31),
        .RST_MONTH    (5'h12),
        .RST_YEAR     (16'h9999)
    ) dut_eoy (
        .clk (clk),
        .clr (clr),
        .bus (bus_eoy)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic check_date(input string tag, input logic [15:0] y,
                              input logic [4:0] m, input logic [5:0] d);
        check({tag, " year"},  {bus.year_h, bus.year_l}, y);
        check({tag, " month"}, 16'(bus.month), 16'(m));
        check({tag, " day"},   16'(bus.day), 16'(d));
    endtask

    task automatic press(input int hold);
        bus.add_n = 1'b0;
        ticks(hold);
        bus.add_n = 1'b1;
        ticks(8);
    endtask

    task automatic press_n(input int n);
        repeat (n) press(DB + 4);
    endtask

    task automatic run_carry();
        bus.day_carry = 1'b1;
        tick();
        bus.day_carry = 1'b0;
        ticks(2);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        clr           = 1'b0;
        bus.day_carry = 1'b0;
        bus.adjust    = 1'b0;
        bus.select    = 4'd0;
        bus.add_n     = 1'b1;
        ticks(3);

        // Reset state of both instances
        check_date("reset", 16'h2000, 5'h01, 6'h01);
        check("reset busy", 16'(bus.busy), 16'd0);
        check("reset leap", 16'(bus.leap), 16'd1);
        check("eoy reset year", {bus_eoy.year_h, bus_eoy.year_l}, 16'h9999);
        check("eoy reset leap", 16'(bus_eoy.leap), 16'd0);
        check("eoy reset busy", 16'(bus_eoy.busy), 16'd0);
        clr = 1'b1;
        tick();

        // First rollover: busy for exactly the UPDATE cycle
        bus.day_carry = 1'b1;
        tick();
        bus.day_carry = 1'b0;
        tick();
        check("carry1 busy in update", 16'(bus.busy), 16'd1);
        check("carry1 day before write", 16'(bus.day), 16'h01);
        tick();
        check("carry1 busy after", 16'(bus.busy), 16'd0);
        check_date("carry1", 16'h2000, 5'h01, 6'h02);
        check("eoy wrap year", {bus_eoy.year_h, bus_eoy.year_l}, 16'h0000);
        check("eoy wrap month", 16'(bus_eoy.month), 16'h01);
        check("eoy wrap day", 16'(bus_eoy.day), 16'h01);
        check("eoy 0000 leap", 16'(bus_eoy.leap), 16'd1);

        // Adjust day to 31, then wrap to 01 without touching the month
        bus.adjust = 1'b1;
        bus.select = SEL_DAY;
        press_n(29);
        check_date("adj day 31", 16'h2000, 5'h01, 6'h31);
        press(DB + 10);
        check_date("adj day wrap", 16'h2000, 5'h01, 6'h01);

        // Short glitch is rejected
        bus.add_n = 1'b0;
        ticks(3);
        bus.add_n = 1'b1;
        ticks(DB + 6);
        check_date("glitch", 16'h2000, 5'h01, 6'h01);

        // Non-field select code ignores presses
        bus.select = 4'd7;
        press(DB + 4);
        check_date("bad select", 16'h2000, 5'h01, 6'h01);

        // Preset 2000-02-28, then leap-century rollovers
        bus.select = SEL_MONTH;
        press(DB + 4);
        bus.select = SEL_DAY;
        press_n(27);
        check_date("preset 2000-02-28", 16'h2000, 5'h02, 6'h28);
        bus.adjust = 1'b0;
        tick();
        run_carry();
        check_date("leap feb 29", 16'h2000, 5'h02, 6'h29);
        run_carry();
        check_date("leap mar 01", 16'h2000, 5'h03, 6'h01);

        // Preset 2100-02-28 (non-leap century)
        bus.adjust = 1'b1;
        bus.select = SEL_MONTH;
        press_n(11);
        bus.select = SEL_YEAR;
        press_n(100);
        check_date("preset 2100-02-01", 16'h2100, 5'h02, 6'h01);
        check("2100 leap", 16'(bus.leap), 16'd0);
        bus.select = SEL_DAY;
        press_n(27);
        bus.adjust = 1'b0;
        tick();
        run_carry();
        check_date("2100 feb 28 rollover", 16'h2100, 5'h03, 6'h01);

        // Preset 2101-01-31, then month increment clamps the day
        bus.adjust = 1'b1;
        bus.select = SEL_YEAR;
        press(DB + 4);
        bus.select = SEL_MONTH;
        press_n(10);
        bus.select = SEL_DAY;
        press_n(30);
        check_date("preset 2101-01-31", 16'h2101, 5'h01, 6'h31);
        bus.select = SEL_MONTH;
        bus.add_n  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < DB + 10; i++) begin
            tick();
            if (bus.busy) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            $error("FAIL clamp press timeout observed=busy_low required=busy_high");
        end
        check("clamp update busy", 16'(bus.busy), 16'd1);
        tick();
        check("clamp cycle busy", 16'(bus.busy), 16'd1);
        check("clamp cycle month", 16'(bus.month), 16'h02);
        check("clamp cycle day", 16'(bus.day), 16'h31);
        tick();
        check("clamp done busy", 16'(bus.busy), 16'd0);
        check_date("clamp done", 16'h2101, 5'h02, 6'h28);
        bus.add_n = 1'b1;
        ticks(8);

        // day_carry is ignored in adjust mode and leaves nothing pending
        bus.day_carry = 1'b1;
        tick();
        bus.day_carry = 1'b0;
        ticks(4);
        check_date("carry in adjust", 16'h2101, 5'h02, 6'h28);
        bus.adjust = 1'b0;
        ticks(4);
        check_date("no latent carry", 16'h2101, 5'h02, 6'h28);

        // Reset asserted during UPDATE wins
        bus.day_carry = 1'b1;
        tick();
        bus.day_carry = 1'b0;
        tick();
        check("pre-reset busy", 16'(bus.busy), 16'd1);
        clr = 1'b0;
        tick();
        check("reset mid-update busy", 16'(bus.busy), 16'd0);
        check_date("reset mid-update", 16'h2000, 5'h01, 6'h01);
        clr = 1'b1;
        ticks(3);
        check("post reset busy", 16'(bus.busy), 16'd0);
        check_date("post reset", 16'h2000, 5'h01, 6'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
